// File: rtl/ita_disp_sched.sv
// Scan scheduler for a 12-digit 14-segment multiplexed display.
// Optional scrolling is built when DISP_SCROLL_EN is defined.
module ita_disp_sched #(
  parameter int NDIG       = 12,
  parameter int SEGW       = 14,
  parameter int DWELL      = 1000,
  parameter int BLANK_CYC  = 4,
  parameter int SCROLL_DIV = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [SEGW-1:0] wr_data,
  input  logic            scroll_on,
  output logic            wr_err,
  output logic            frame_done,
  output logic [NDIG-1:0] sel,
  output logic [SEGW-1:0] segm
);

  localparam int MX1  = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int MAXC = (MX1 > SCROLL_DIV) ? MX1 : SCROLL_DIV;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DW_M1 = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL    = CW'(BLANK_CYC);
  localparam logic [CW-1:0] BL_M1 = CW'(BLANK_CYC - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [3:0]      idx;
  logic [3:0]      nidx;
  logic [3:0]      offset;
  logic            last;
  logic            frame_evt;
  logic [SEGW-1:0] gbuf [NDIG];

  function automatic logic [3:0] gidx(input logic [3:0] i,
                                      input logic [3:0] o);
    logic [4:0] s;
    s = {1'b0, i} + {1'b0, o};
    if (s >= 5'(NDIG)) s = s - 5'(NDIG);
    return s[3:0];
  endfunction

  function automatic logic [NDIG-1:0] oh(input logic [3:0] i);
    return {{(NDIG-1){1'b0}}, 1'b1} << i;
  endfunction

  assign nidx = (idx == 4'(NDIG - 1)) ? 4'd0 : idx + 4'd1;
  assign last = (cnt == '0) && (idx == 4'(NDIG - 1));
  assign frame_evt = en && (state == S_SHOW) && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) gbuf[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && ({1'b0, wr_addr} >= 5'(NDIG));
      if (wr_en && ({1'b0, wr_addr} < 5'(NDIG)))
        gbuf[wr_addr] <= wr_data;
    end
  end

  // sel/segm are latched only on SHOW entry so a lit digit never changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      cnt        <= '0;
      idx        <= '0;
      sel        <= '0;
      segm       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state <= S_OFF;
        cnt   <= '0;
        idx   <= '0;
        sel   <= '0;
        segm  <= '0;
      end else begin
        unique case (state)
          S_OFF: begin
            state <= S_BLANK;
            cnt   <= BL;
            idx   <= '0;
          end
          S_BLANK: begin
            if (cnt == '0) begin
              state <= S_SHOW;
              cnt   <= DW_M1;
              sel   <= oh(idx);
              segm  <= gbuf[gidx(idx, offset)];
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_SHOW: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              frame_done <= last;
              idx        <= nidx;
              if (BLANK_CYC == 0) begin
                state <= S_SHOW;
                cnt   <= DW_M1;
                sel   <= oh(nidx);
                segm  <= gbuf[gidx(nidx, offset)];
              end else begin
                state <= S_BLANK;
                cnt   <= BL_M1;
                sel   <= '0;
                segm  <= '0;
              end
            end
          end
          default: begin
            state <= S_OFF;
            cnt   <= '0;
            idx   <= '0;
            sel   <= '0;
            segm  <= '0;
          end
        endcase
      end
    end
  end

`ifdef DISP_SCROLL_EN
  localparam logic [CW-1:0] SD_M1 = CW'(SCROLL_DIV - 1);
  logic [CW-1:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt   <= '0;
      offset <= '0;
    end else if (!scroll_on) begin
      fcnt <= '0;
    end else if (frame_evt) begin
      if (fcnt == SD_M1) begin
        fcnt   <= '0;
        offset <= (offset == 4'(NDIG - 1)) ? 4'd0 : offset + 4'd1;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = scroll_on ^ frame_evt;
  assign offset = '0;
`endif

endmodule

// File: tb/tb_ita_disp_sched.sv
// Randomized bench for ita_disp_sched against a timeline-based model.
// Model derives each output from the cycle position since scan start.
module tb_ita_disp_sched;

  localparam int NDIG  = 12;
  localparam int SEGW  = 14;
  localparam int DWELL = 3;
  localparam int BLANK = 1;
  localparam int SDIV  = 2;
  localparam int P     = BLANK + DWELL;
  localparam int FR    = P * NDIG;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            wr_en = 1'b0;
  logic [3:0]      wr_addr = '0;
  logic [SEGW-1:0] wr_data = '0;
  logic            scroll_on = 1'b0;
  logic            wr_err;
  logic            frame_done;
  logic [NDIG-1:0] sel;
  logic [SEGW-1:0] segm;

  int nchk = 0;
  int npass = 0;

  logic [SEGW-1:0] mbuf [NDIG];
  logic [SEGW-1:0] lat;
  logic [NDIG-1:0] esel;
  logic [SEGW-1:0] eseg;
  logic            efd;
  logic            eerr;
  bit              run;
  int              j;
  int              off;
  int              fc;

  ita_disp_sched #(
    .NDIG(NDIG), .SEGW(SEGW), .DWELL(DWELL),
    .BLANK_CYC(BLANK), .SCROLL_DIV(SDIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scroll_on(scroll_on), .wr_err(wr_err),
    .frame_done(frame_done), .sel(sel), .segm(segm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic mreset();
    for (int i = 0; i < NDIG; i++) mbuf[i] = '0;
    lat = '0; esel = '0; eseg = '0; efd = 0; eerr = 0;
    run = 0; j = 0; off = 0; fc = 0;
  endtask

  // one clock of reference behaviour for the inputs seen at this edge
  task automatic model(input logic e, input logic w, input logic [3:0] a,
                       input logic [SEGW-1:0] d, input logic so);
    int dig;
    efd = 0;
    if (!e) begin
      run = 0; esel = '0; eseg = '0;
    end else begin
      if (!run) begin run = 1; j = -1; end
      else j++;
      efd = (j > 0) && (j % FR == 0);
      if (j >= 0 && (j % P) >= BLANK) begin
        dig = (j / P) % NDIG;
        if ((j % P) == BLANK) lat = mbuf[(dig + off) % NDIG];
        esel = NDIG'(1) << dig;
        eseg = lat;
      end else begin
        esel = '0; eseg = '0;
      end
    end
`ifdef DISP_SCROLL_EN
    if (!so) fc = 0;
    else if (efd) begin
      fc++;
      if (fc == SDIV) begin fc = 0; off = (off + 1) % NDIG; end
    end
`else
    if (so) fc = 0;
`endif
    eerr = w && (a >= NDIG);
    if (w && a < NDIG) mbuf[a] = d;
  endtask

  task automatic step(input logic e, input logic w, input logic [3:0] a,
                      input logic [SEGW-1:0] d, input logic so);
    @(negedge clk);
    en = e; wr_en = w; wr_addr = a; wr_data = d; scroll_on = so;
    @(posedge clk);
    model(e, w, a, d, so);
    #1;
    chk("sel", sel, esel);
    chk("segm", segm, eseg);
    chk("frame_done", frame_done, efd);
    chk("wr_err", wr_err, eerr);
  endtask

  initial begin
    int k;
    int lowleft;
    bit so;
    logic w;
    logic [3:0] a;
    int nj;

    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_segm", segm, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", wr_err, 0);
    @(negedge clk);
    rst = 1'b0;

    step(0, 1, 4'd0, 14'h3F40, 0);
    step(0, 1, 4'd1, 14'h2380, 0);
    for (int c = 1; c <= 8; c++) begin
      step(1, 0, 4'd0, '0, 0);
      if (c == 2) chk("t1_blank", sel, 0);
      if (c == 3) begin
        chk("t1_sel0", sel, 12'h001);
        chk("t1_seg0", segm, 14'h3F40);
      end
      if (c == 5) chk("t1_hold0", segm, 14'h3F40);
      if (c == 6) chk("t1_gap", sel, 0);
      if (c == 7) begin
        chk("t1_sel1", sel, 12'h002);
        chk("t1_seg1", segm, 14'h2380);
      end
    end

    for (int c = 9; c <= 50; c++) step(1, 0, 4'd0, '0, 0);
    chk("t2_fd", frame_done, 1);
    step(1, 0, 4'd0, '0, 0);
    chk("t2_fd_end", frame_done, 0);
    chk("t2_wrap", sel, 12'h001);

    step(1, 1, 4'd12, 14'h1555, 0);
    chk("t3_err", wr_err, 1);
    step(1, 0, 4'd0, '0, 0);
    chk("t3_err_end", wr_err, 0);

    k = 0;
    while (!(esel == 12'h020 && (j % P) == BLANK + 1) && k < 200) begin
      step(1, 0, 4'd0, '0, 0);
      k++;
    end
    chk("t4_found", k < 200, 1);
    step(0, 0, 4'd0, '0, 0);
    chk("t4_off_sel", sel, 0);
    chk("t4_off_seg", segm, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 4'd0, '0, 0);
    for (int c = 1; c <= 3; c++) begin
      step(1, 0, 4'd0, '0, 0);
      if (c == 2) chk("t4_blank", sel, 0);
      if (c == 3) chk("t4_restart", sel, 12'h001);
    end

    lowleft = 0;
    so = 0;
    for (int c = 0; c < 6000; c++) begin
      if (lowleft > 0) lowleft--;
      else if ($urandom_range(299) == 0) lowleft = $urandom_range(6, 1);
      if ($urandom_range(499) == 0) so = ~so;
      w = ($urandom_range(9) < 4);
      a = 4'($urandom_range(15));
      nj = run ? j + 1 : -1;
      if (lowleft == 0 && run && nj >= 0 && (nj % P) == BLANK
          && $urandom_range(1) == 1) begin
        w = 1;
        a = 4'(((nj / P) % NDIG + off) % NDIG);
      end
      step(lowleft == 0, w, a, SEGW'($urandom), so);

      if (c == 3000) begin
        k = 0;
        while (esel == '0 && k < 50) begin
          step(1, 0, 4'd0, '0, so);
          k++;
        end
        chk("t5_lit", esel != '0, 1);
        #2 rst = 1'b1;
        en = 1'b0; wr_en = 1'b0;
        #1;
        chk("t5_rst_sel", sel, 0);
        chk("t5_rst_seg", segm, 0);
        chk("t5_rst_fd", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        mreset();
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
